id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly downstream of the opcode decoder, between the decode stage and the ALU/EX stage.
- Latches the decoder control bundle together with decode-stage operands, and inserts bubbles on flush.
- Holds its contents when EX is busy.
- Contains the load-use hazard detector. It drives Stall back to the PC and the IF/ID register.
- Keeps a saturating count of load-use bubbles for performance debug.

---
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Flush inserts a bubble, Hold freezes EX, and load-use bubbles are counted.
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [5:0]      ID_OpCode,
    input  logic            ID_RegWrite,
    input  logic            ID_ALUSrc1Mux,
    input  logic [1:0]      ID_RegDestMux,
    input  logic [1:0]      ID_MemRead,
    input  logic [1:0]      ID_MemWrite,
    input  logic [2:0]      ID_MemToRegMux,
    input  logic [4:0]      ID_ALUOp,
    input  logic [DW-1:0]   ID_ReadData1,
    input  logic [DW-1:0]   ID_ReadData2,
    input  logic [DW-1:0]   ID_Imm,
    input  logic [DW-1:0]   ID_PCPlus4,
    input  logic [4:0]      ID_Rs,
    input  logic [4:0]      ID_Rt,
    input  logic [4:0]      ID_Rd,
    input  logic [4:0]      ID_Shamt,
    input  logic            Flush,
    input  logic            Hold,
    output logic            EX_RegWrite,
    output logic            EX_ALUSrc1Mux,
    output logic [1:0]      EX_RegDestMux,
    output logic [1:0]      EX_MemRead,
    output logic [1:0]      EX_MemWrite,
    output logic [2:0]      EX_MemToRegMux,
    output logic [4:0]      EX_ALUOp,
    output logic [DW-1:0]   EX_ReadData1,
    output logic [DW-1:0]   EX_ReadData2,
    output logic [DW-1:0]   EX_Imm,
    output logic [DW-1:0]   EX_PCPlus4,
    output logic [4:0]      EX_Rs,
    output logic [4:0]      EX_Rt,
    output logic [4:0]      EX_Rd,
    output logic [4:0]      EX_Shamt,
    output logic [4:0]      EX_WriteReg,
    output logic            EX_Valid,
    output logic            Stall,
    output logic [CNTW-1:0] BubbleCount
);

    typedef struct packed {
        logic          rw;
        logic          a1;
        logic [1:0]    rdm;
        logic [1:0]    mr;
        logic [1:0]    mw;
        logic [2:0]    m2r;
        logic [4:0]    aluop;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [4:0]    sh;
        logic [4:0]    wr;
        logic          v;
    } ex_t;

    ex_t             r_ex;
    ex_t             w_id;
    logic [CNTW-1:0] r_bc;
    logic [4:0]      w_wreg;
    logic            w_uses_rs;
    logic            w_uses_rt;
    logic            w_rs_hit;
    logic            w_rt_hit;
    logic            w_load_use;

    always_comb begin
        w_wreg = 5'd0;
        unique case (ID_RegDestMux)
            2'd0: w_wreg = ID_Rt;
            2'd1: w_wreg = ID_Rd;
            2'd2: w_wreg = 5'd31;
            2'd3: w_wreg = 5'd0;
        endcase
        if (!ID_RegWrite) w_wreg = 5'd0;
    end

    assign w_uses_rs = !(ID_OpCode inside {6'b000010, 6'b000011, 6'b001111});
    assign w_uses_rt = ID_OpCode inside {6'b000000, 6'b011100, 6'b011111,
                                         6'b000100, 6'b000101, 6'b101011,
                                         6'b101000, 6'b101001};

    assign w_rs_hit = w_uses_rs && (ID_Rs == r_ex.wr);
    assign w_rt_hit = w_uses_rt && (ID_Rt == r_ex.wr);

    // Register 0 is excluded through the wr != 0 term
    assign w_load_use = r_ex.v && (r_ex.mr != 2'd0) && (r_ex.wr != 5'd0)
                        && (w_rs_hit || w_rt_hit);

    always_comb begin
        w_id       = '0;
        w_id.rw    = ID_RegWrite;
        w_id.a1    = ID_ALUSrc1Mux;
        w_id.rdm   = ID_RegDestMux;
        w_id.mr    = ID_MemRead;
        w_id.mw    = ID_MemWrite;
        w_id.m2r   = ID_MemToRegMux;
        w_id.aluop = ID_ALUOp;
        w_id.rd1   = ID_ReadData1;
        w_id.rd2   = ID_ReadData2;
        w_id.imm   = ID_Imm;
        w_id.pc4   = ID_PCPlus4;
        w_id.rs    = ID_Rs;
        w_id.rt    = ID_Rt;
        w_id.rd    = ID_Rd;
        w_id.sh    = ID_Shamt;
        w_id.wr    = w_wreg;
        w_id.v     = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_ex <= '0;
            r_bc <= '0;
        end else if (Flush) begin
            r_ex <= '0;
        end else if (Hold) begin
            r_ex <= r_ex;
        end else if (w_load_use) begin
            r_ex <= '0;
            if (r_bc != {CNTW{1'b1}}) r_bc <= r_bc + CNTW'(1);
        end else begin
            r_ex <= w_id;
        end
    end

    assign Stall          = (w_load_use || Hold) && Rst;
    assign BubbleCount    = r_bc;
    assign EX_RegWrite    = r_ex.rw;
    assign EX_ALUSrc1Mux  = r_ex.a1;
    assign EX_RegDestMux  = r_ex.rdm;
    assign EX_MemRead     = r_ex.mr;
    assign EX_MemWrite    = r_ex.mw;
    assign EX_MemToRegMux = r_ex.m2r;
    assign EX_ALUOp       = r_ex.aluop;
    assign EX_ReadData1   = r_ex.rd1;
    assign EX_ReadData2   = r_ex.rd2;
    assign EX_Imm         = r_ex.imm;
    assign EX_PCPlus4     = r_ex.pc4;
    assign EX_Rs          = r_ex.rs;
    assign EX_Rt          = r_ex.rt;
    assign EX_Rd          = r_ex.rd;
    assign EX_Shamt       = r_ex.sh;
    assign EX_WriteReg    = r_ex.wr;
    assign EX_Valid       = r_ex.v;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: default instance plus a CNTW=2 copy
// sharing the same stimulus to exercise counter saturation.
module tb_id_ex_stage;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [5:0]  op;
    logic        rw, a1;
    logic [1:0]  rdm, mr, mw;
    logic [2:0]  m2r;
    logic [4:0]  aluop;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd, sh;
    logic        Flush = 1'b0;
    logic        Hold = 1'b0;

    logic        e_rw, e_a1, e_v, stall;
    logic [1:0]  e_rdm, e_mr, e_mw;
    logic [2:0]  e_m2r;
    logic [4:0]  e_aluop, e_rs, e_rt, e_rd, e_sh, e_wr;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc4;
    logic [15:0] bc;

    logic        s_rw, s_a1, s_v, stall2;
    logic [1:0]  s_rdm, s_mr, s_mw;
    logic [2:0]  s_m2r;
    logic [4:0]  s_aluop, s_rs, s_rt, s_rd, s_sh, s_wr;
    logic [31:0] s_rd1, s_rd2, s_imm, s_pc4;
    logic [1:0]  bc2;

    always #5 Clk = ~Clk;

    id_ex_stage dut (
        .Clk(Clk), .Rst(Rst), .ID_OpCode(op), .ID_RegWrite(rw),
        .ID_ALUSrc1Mux(a1), .ID_RegDestMux(rdm), .ID_MemRead(mr),
        .ID_MemWrite(mw), .ID_MemToRegMux(m2r), .ID_ALUOp(aluop),
        .ID_ReadData1(rd1), .ID_ReadData2(rd2), .ID_Imm(imm),
        .ID_PCPlus4(pc4), .ID_Rs(rs), .ID_Rt(rt), .ID_Rd(rd),
        .ID_Shamt(sh), .Flush(Flush), .Hold(Hold),
        .EX_RegWrite(e_rw), .EX_ALUSrc1Mux(e_a1), .EX_RegDestMux(e_rdm),
        .EX_MemRead(e_mr), .EX_MemWrite(e_mw), .EX_MemToRegMux(e_m2r),
        .EX_ALUOp(e_aluop), .EX_ReadData1(e_rd1), .EX_ReadData2(e_rd2),
        .EX_Imm(e_imm), .EX_PCPlus4(e_pc4), .EX_Rs(e_rs), .EX_Rt(e_rt),
        .EX_Rd(e_rd), .EX_Shamt(e_sh), .EX_WriteReg(e_wr),
        .EX_Valid(e_v), .Stall(stall), .BubbleCount(bc)
    );

    id_ex_stage #(.DW(32), .CNTW(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .ID_OpCode(op), .ID_RegWrite(rw),
        .ID_ALUSrc1Mux(a1), .ID_RegDestMux(rdm), .ID_MemRead(mr),
        .ID_MemWrite(mw), .ID_MemToRegMux(m2r), .ID_ALUOp(aluop),
        .ID_ReadData1(rd1), .ID_ReadData2(rd2), .ID_Imm(imm),
        .ID_PCPlus4(pc4), .ID_Rs(rs), .ID_Rt(rt), .ID_Rd(rd),
        .ID_Shamt(sh), .Flush(Flush), .Hold(Hold),
        .EX_RegWrite(s_rw), .EX_ALUSrc1Mux(s_a1), .EX_RegDestMux(s_rdm),
        .EX_MemRead(s_mr), .EX_MemWrite(s_mw), .EX_MemToRegMux(s_m2r),
        .EX_ALUOp(s_aluop), .EX_ReadData1(s_rd1), .EX_ReadData2(s_rd2),
        .EX_Imm(s_imm), .EX_PCPlus4(s_pc4), .EX_Rs(s_rs), .EX_Rt(s_rt),
        .EX_Rd(s_rd), .EX_Shamt(s_sh), .EX_WriteReg(s_wr),
        .EX_Valid(s_v), .Stall(stall2), .BubbleCount(bc2)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic        rw;
        logic        a1;
        logic [1:0]  rdm;
        logic [1:0]  mr;
        logic [1:0]  mw;
        logic [2:0]  m2r;
        logic [4:0]  aluop;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
    } id_t;

    typedef struct packed {
        logic        rw;
        logic        a1;
        logic [1:0]  rdm;
        logic [1:0]  mr;
        logic [1:0]  mw;
        logic [2:0]  m2r;
        logic [4:0]  aluop;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [4:0]  wr;
        logic        v;
        logic [15:0] bc;
        logic [1:0]  bc2;
    } ex_t;

    ex_t q[$];
    ex_t m = '0;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic id_t rnd();
        id_t x;
        x.op    = 6'($urandom);
        x.rw    = 1'($urandom);
        x.a1    = 1'($urandom);
        x.rdm   = 2'($urandom);
        x.mr    = 2'($urandom);
        x.mw    = 2'($urandom);
        x.m2r   = 3'($urandom);
        x.aluop = 5'($urandom);
        x.rd1   = $urandom;
        x.rd2   = $urandom;
        x.imm   = $urandom;
        x.pc4   = $urandom;
        x.rs    = 5'($urandom);
        x.rt    = 5'($urandom);
        x.rd    = 5'($urandom);
        x.sh    = 5'($urandom);
        return x;
    endfunction

    function automatic id_t mk(input logic [5:0] o, input logic w,
                               input logic [1:0] dm, input logic [1:0] rdmem,
                               input logic [2:0] mtr, input logic [4:0] s,
                               input logic [4:0] t, input logic [4:0] d);
        id_t x = rnd();
        x.op    = o;
        x.rw    = w;
        x.rdm   = dm;
        x.mr    = rdmem;
        x.mw    = 2'd0;
        x.m2r   = mtr;
        x.aluop = 5'd2;
        x.rs    = s;
        x.rt    = t;
        x.rd    = d;
        return x;
    endfunction

    function automatic logic hazard(input ex_t s, input id_t x);
        logic urs, urt;
        logic [4:0] w;
        urs = 1'b1;
        urt = 1'b0;
        case (x.op)
            6'b000010, 6'b000011, 6'b001111: urs = 1'b0;
            default: ;
        endcase
        case (x.op)
            6'b000000, 6'b011100, 6'b011111, 6'b000100,
            6'b000101, 6'b101011, 6'b101000, 6'b101001: urt = 1'b1;
            default: ;
        endcase
        w = s.wr;
        if (!s.v || s.mr == 2'd0 || w == 5'd0) return 1'b0;
        return (urs && x.rs == w) || (urt && x.rt == w);
    endfunction

    function automatic ex_t nxt(input ex_t s, input id_t x, input logic r,
                                input logic f, input logic h, input logic lu);
        ex_t n;
        n = '0;
        if (!r) return n;
        n.bc  = s.bc;
        n.bc2 = s.bc2;
        if (f) return n;
        if (h) return s;
        if (lu) begin
            if (n.bc != 16'hffff) n.bc = n.bc + 16'd1;
            if (n.bc2 != 2'd3) n.bc2 = n.bc2 + 2'd1;
            return n;
        end
        n.rw = x.rw; n.a1 = x.a1; n.rdm = x.rdm; n.mr = x.mr;
        n.mw = x.mw; n.m2r = x.m2r; n.aluop = x.aluop;
        n.rd1 = x.rd1; n.rd2 = x.rd2; n.imm = x.imm; n.pc4 = x.pc4;
        n.rs = x.rs; n.rt = x.rt; n.rd = x.rd; n.sh = x.sh;
        case (x.rdm)
            2'd0: n.wr = x.rt;
            2'd1: n.wr = x.rd;
            2'd2: n.wr = 5'd31;
            default: n.wr = 5'd0;
        endcase
        if (!x.rw) n.wr = 5'd0;
        n.v = 1'b1;
        return n;
    endfunction

    task automatic cyc(input id_t x, input logic r, input logic f,
                       input logic h);
        logic lu;
        ex_t  e;
        op = x.op; rw = x.rw; a1 = x.a1; rdm = x.rdm; mr = x.mr;
        mw = x.mw; m2r = x.m2r; aluop = x.aluop; rd1 = x.rd1;
        rd2 = x.rd2; imm = x.imm; pc4 = x.pc4; rs = x.rs; rt = x.rt;
        rd = x.rd; sh = x.sh;
        Rst = r; Flush = f; Hold = h;
        #1;
        lu = hazard(m, x);
        chk("stall", 64'(stall), 64'((lu | h) & r));
        chk("stall2", 64'(stall2), 64'((lu | h) & r));
        q.push_back(nxt(m, x, r, f, h, lu));
        m = nxt(m, x, r, f, h, lu);
        @(posedge Clk);
        #1;
        e = q.pop_front();
        chk("ctl", 64'({e_rw, e_a1, e_rdm, e_mr, e_mw, e_m2r, e_aluop}),
            64'({e.rw, e.a1, e.rdm, e.mr, e.mw, e.m2r, e.aluop}));
        chk("rd", {e_rd1, e_rd2}, {e.rd1, e.rd2});
        chk("imm_pc", {e_imm, e_pc4}, {e.imm, e.pc4});
        chk("regs", 64'({e_rs, e_rt, e_rd, e_sh}),
            64'({e.rs, e.rt, e.rd, e.sh}));
        chk("wreg", 64'(e_wr), 64'(e.wr));
        chk("valid", 64'(e_v), 64'(e.v));
        chk("bcount", 64'(bc), 64'(e.bc));
        chk("bcount2", 64'(bc2), 64'(e.bc2));
        chk("valid2", 64'({s_v, s_wr, s_aluop}), 64'({e.v, e.wr, e.aluop}));
    endtask

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic [5:0] ops [8];

    initial begin
        ops[0] = OP_ADD;  ops[1] = OP_LW;  ops[2] = OP_ADDI;
        ops[3] = OP_JAL;  ops[4] = OP_SW;  ops[5] = 6'b001111;
        ops[6] = 6'b000100; ops[7] = 6'b000010;
        @(posedge Clk);
        #1;
        cyc(rnd(), 1'b0, 1'b0, 1'b0);
        cyc(rnd(), 1'b0, 1'b1, 1'b1);
        cyc(mk(OP_ADD, 1, 2'd1, 0, 3'd0, 5'd1, 5'd2, 5'd3), 1, 0, 0);
        // Load-use: LW rt=8 then ADD rs=8, held ADD re-presented
        cyc(mk(OP_LW, 1, 2'd0, 2'd1, 3'd1, 5'd4, 5'd8, 5'd0), 1, 0, 0);
        cyc(mk(OP_ADD, 1, 2'd1, 0, 3'd0, 5'd8, 5'd3, 5'd9), 1, 0, 0);
        cyc(mk(OP_ADD, 1, 2'd1, 0, 3'd0, 5'd8, 5'd3, 5'd9), 1, 0, 0);
        // No false stall
        cyc(mk(OP_LW, 1, 2'd0, 2'd1, 3'd1, 5'd4, 5'd8, 5'd0), 1, 0, 0);
        cyc(mk(OP_ADDI, 1, 2'd0, 0, 3'd0, 5'd9, 5'd8, 5'd0), 1, 0, 0);
        cyc(mk(OP_LW, 1, 2'd0, 2'd1, 3'd1, 5'd4, 5'd0, 5'd0), 1, 0, 0);
        cyc(mk(OP_ADD, 1, 2'd1, 0, 3'd0, 5'd0, 5'd0, 5'd5), 1, 0, 0);
        // Store consuming a loaded rt
        cyc(mk(OP_LW, 1, 2'd0, 2'd1, 3'd1, 5'd4, 5'd7, 5'd0), 1, 0, 0);
        cyc(mk(OP_SW, 0, 2'd0, 0, 3'd0, 5'd2, 5'd7, 5'd0), 1, 0, 0);
        cyc(mk(OP_SW, 0, 2'd0, 0, 3'd0, 5'd2, 5'd7, 5'd0), 1, 0, 0);
        // Hold for 3 cycles with a pending hazard, then flush+hold
        cyc(mk(OP_LW, 1, 2'd0, 2'd1, 3'd1, 5'd4, 5'd8, 5'd0), 1, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(mk(OP_ADD, 1, 2'd1, 0, 3'd0, 5'd8, 5'd3, 5'd9), 1, 0, 1);
        cyc(mk(OP_ADD, 1, 2'd1, 0, 3'd0, 5'd8, 5'd3, 5'd9), 1, 1, 1);
        // JAL then LW rs=31
        cyc(mk(OP_JAL, 1, 2'd2, 0, 3'b100, 5'd0, 5'd0, 5'd0), 1, 0, 0);
        cyc(mk(OP_LW, 1, 2'd0, 2'd1, 3'd1, 5'd31, 5'd6, 5'd0), 1, 0, 0);
        // Saturation of the narrow counter from a fresh reset
        cyc(rnd(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(mk(OP_LW, 1, 2'd0, 2'd1, 3'd1, 5'd4, 5'd8, 5'd0), 1, 0, 0);
            cyc(mk(OP_ADD, 1, 2'd1, 0, 3'd0, 5'd8, 5'd3, 5'd9), 1, 0, 0);
        end
        chk("sat2", 64'(bc2), 64'd3);
        chk("sat16", 64'(bc), 64'd5);
        for (int i = 0; i < 300; i++) begin
            id_t x;
            x = rnd();
            x.op = ops[$urandom_range(0, 7)];
            x.rs = 5'($urandom_range(0, 3));
            x.rt = 5'($urandom_range(0, 3));
            x.rd = 5'($urandom_range(0, 3));
            cyc(x, $urandom_range(0, 29) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
